// File: rtl/mmio_input_port.sv
// Memory-mapped input peripheral: switch and button synchronisers, per-button
// debounce, sticky rising-edge flags (write-1-to-clear) and a level interrupt.
// Read data is combinational so the MEM-stage load path sees it the same cycle.

// One debounce lane: accepts a new synchronised level after it has held
// for CNT_MAX+1 consecutive cycles; any return to the stable level restarts.
module mmio_input_port_db #(
    parameter int              CNT_W   = 20,
    parameter logic [CNT_W-1:0] CNT_MAX = '1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_s,
    output logic o_q,
    output logic o_rise
);
    logic [CNT_W-1:0] r_cnt;
    logic             r_q;
    logic             w_diff;
    logic             w_done;

    assign w_diff = (i_s != r_q);
    assign w_done = w_diff && (r_cnt == CNT_MAX);

    // Count consecutive disagreeing samples; flip the stable level on the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_q   <= 1'b0;
        end else if (!w_diff) begin
            r_cnt <= '0;
        end else if (w_done) begin
            r_q   <= i_s;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_q    = r_q;
    // Pulses in the cycle whose edge raises q, so the edge flag sets alongside it.
    assign o_rise = w_done & i_s;
endmodule

module mmio_input_port #(
    parameter int NUM_SW          = 8,
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 20'd1000000,
    parameter int CNT_W           = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               memRead,
    input  logic               memWrite,
    input  logic [31:0]        address,
    input  logic [31:0]        dataIn,
    input  logic [NUM_SW-1:0]  sw,
    input  logic [NUM_BTN-1:0] btn,
    output logic [31:0]        dataOut,
    output logic               irq
);
    localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Word addresses (byte address >> 2).
    localparam logic [29:0] LP_A_SW   = 30'h1000_0005;
    localparam logic [29:0] LP_A_BTN  = 30'h1000_0006;
    localparam logic [29:0] LP_A_EDGE = 30'h1000_0007;
    localparam logic [29:0] LP_A_IEN  = 30'h1000_0008;

    logic [NUM_SW-1:0]  r_sw_s1, r_sw_s2;
    logic [NUM_BTN-1:0] r_btn_s1, r_btn_s2;
    logic [NUM_BTN-1:0] w_q, w_rise;
    logic [NUM_BTN-1:0] r_edge, r_ien;
    logic [NUM_BTN-1:0] w_clr;
    logic               r_irq;
    logic               w_sel_sw, w_sel_btn, w_sel_edge, w_sel_ien;
    logic               w_unused;

    assign w_sel_sw   = (address[31:2] == LP_A_SW);
    assign w_sel_btn  = (address[31:2] == LP_A_BTN);
    assign w_sel_edge = (address[31:2] == LP_A_EDGE);
    assign w_sel_ien  = (address[31:2] == LP_A_IEN);

    // Byte offsets and unstored data bits are deliberately ignored.
    assign w_unused = ^{address[1:0], dataIn[31:NUM_BTN]};

    // Two-flop synchronisers for all asynchronous inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
        end else begin
            r_sw_s1  <= sw;
            r_sw_s2  <= r_sw_s1;
            r_btn_s1 <= btn;
            r_btn_s2 <= r_btn_s1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_db
            mmio_input_port_db #(
                .CNT_W   (CNT_W),
                .CNT_MAX (LP_CNT_MAX)
            ) u_db (
                .clk    (clk),
                .rst    (rst),
                .i_s    (r_btn_s2[gi]),
                .o_q    (w_q[gi]),
                .o_rise (w_rise[gi])
            );
        end
    endgenerate

    assign w_clr = (memWrite && w_sel_edge) ? dataIn[NUM_BTN-1:0] : '0;

    // Sticky flags (set beats clear), enable register and registered interrupt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_edge <= '0;
            r_ien  <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_edge <= (r_edge & ~w_clr) | w_rise;
            if (memWrite && w_sel_ien) r_ien <= dataIn[NUM_BTN-1:0];
            r_irq  <= |(r_edge & r_ien);
        end
    end

    assign irq = r_irq;

    // Zero-latency read mux; unselected or idle reads return 0.
    always_comb begin
        dataOut = '0;
        if (memRead) begin
            if (w_sel_sw)        dataOut[NUM_SW-1:0]  = r_sw_s2;
            else if (w_sel_btn)  dataOut[NUM_BTN-1:0] = w_q;
            else if (w_sel_edge) dataOut[NUM_BTN-1:0] = r_edge;
            else if (w_sel_ien)  dataOut[NUM_BTN-1:0] = r_ien;
        end
    end
endmodule

// File: tb/tb_mmio_input_port.sv
// Randomised and directed bench for mmio_input_port with a window-based
// reference model (a level is accepted once the last D samples all disagree).
module tb_mmio_input_port;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        memRead = 1'b0, memWrite = 1'b0;
    logic [31:0] address = '0, dataIn = '0;
    logic [7:0]  sw = '0;
    logic [3:0]  btn = '0;
    logic [31:0] dataOut;
    logic        irq;

    int n_chk = 0, n_pass = 0;

    mmio_input_port #(
        .NUM_SW(8), .NUM_BTN(4), .DEBOUNCE_CYCLES(D), .CNT_W(20)
    ) dut (
        .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite),
        .address(address), .dataIn(dataIn), .sw(sw), .btn(btn),
        .dataOut(dataOut), .irq(irq)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] m_sw1 = '0, m_sw2 = '0;
    logic [3:0] m_b1 = '0, m_b2 = '0, m_q = '0, m_edge = '0, m_ien = '0;
    logic       m_irq = 1'b0;
    logic [D-1:0] m_win [4];
    int         m_fill [4];

    always @(posedge clk or posedge rst) begin
        logic [3:0] rise;
        if (rst) begin
            m_sw1 = '0; m_sw2 = '0; m_b1 = '0; m_b2 = '0;
            m_q = '0; m_edge = '0; m_ien = '0; m_irq = 1'b0;
            for (int b = 0; b < 4; b++) begin m_win[b] = '0; m_fill[b] = 0; end
        end else begin
            rise  = '0;
            m_irq = |(m_edge & m_ien);
            if (memWrite && address[31:2] == 30'h1000_0007) m_edge = m_edge & ~dataIn[3:0];
            if (memWrite && address[31:2] == 30'h1000_0008) m_ien = dataIn[3:0];
            for (int b = 0; b < 4; b++) begin
                m_win[b] = {m_win[b][D-2:0], m_b2[b]};
                if (m_fill[b] < D) m_fill[b]++;
                if (m_fill[b] == D && m_win[b] == {D{~m_q[b]}}) begin
                    m_q[b] = ~m_q[b];
                    if (m_q[b]) rise[b] = 1'b1;
                end
            end
            m_edge = m_edge | rise;
            m_sw2 = m_sw1; m_sw1 = sw;
            m_b2  = m_b1;  m_b1  = btn;
        end
    end

    function automatic logic [31:0] exp_rd(input logic rd, input logic [31:0] a);
        logic [31:0] v;
        v = '0;
        if (rd) begin
            case (a[31:2])
                30'h1000_0005: v = {24'b0, m_sw2};
                30'h1000_0006: v = {28'b0, m_q};
                30'h1000_0007: v = {28'b0, m_edge};
                30'h1000_0008: v = {28'b0, m_ien};
                default:       v = '0;
            endcase
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("model_rd", dataOut, exp_rd(memRead, address));
        chk("model_irq", {31'b0, irq}, {31'b0, m_irq});
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memWrite = 1'b1; address = a; dataIn = d;
        tick();
        memWrite = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        memRead = 1'b1; address = a;
        #1;
        chk(tag, dataOut, exp);
        memRead = 1'b0;
    endtask

    localparam logic [31:0] A_SW = 32'h4000_0014, A_BTN = 32'h4000_0018,
                            A_EDGE = 32'h4000_001C, A_IEN = 32'h4000_0020;

    initial begin
        logic [31:0] addrs [7];
        addrs = '{A_SW, A_BTN, A_EDGE, A_IEN, 32'h4000_0024, 32'h4000_0010, 32'h0000_001C};

        // Initial reset.
        #1 rst = 1'b1;
        #2;
        rd_chk("rst0_rd", A_SW, 32'h0);
        chk("rst0_irq", {31'b0, irq}, 32'h0);
        ticks(2);
        rst = 1'b0;

        // Reset mid-debounce with everything pressed.
        btn = 4'hF; sw = 8'hFF;
        ticks(3);
        #2 rst = 1'b1;
        rd_chk("rst_mid_sw", A_SW, 32'h0);
        rd_chk("rst_mid_btn", A_BTN, 32'h0);
        chk("rst_mid_irq", {31'b0, irq}, 32'h0);
        tick(); tick();
        rst = 1'b0;
        tick();
        rd_chk("sw_1edge", A_SW, 32'h0);
        tick();
        rd_chk("sw_2edge", A_SW, 32'hFF);
        ticks(3);
        rd_chk("btn_5edge", A_BTN, 32'h0);
        tick();
        rd_chk("btn_6edge", A_BTN, 32'hF);
        rd_chk("edge_6edge", A_EDGE, 32'hF);
        wr(A_EDGE, 32'hF);
        rd_chk("edge_w1c", A_EDGE, 32'h0);
        btn = 4'h0;
        ticks(8);
        rd_chk("btn_fall", A_BTN, 32'h0);
        rd_chk("edge_nofall", A_EDGE, 32'h0);

        // Switch reads.
        sw = 8'hA5;
        tick();
        rd_chk("sw_lag", A_SW, 32'hFF);
        tick();
        rd_chk("sw_a5", A_SW, 32'hA5);
        address = A_SW; memRead = 1'b0; #1;
        chk("sw_nord", dataOut, 32'h0);
        rd_chk("unmapped", 32'h4000_0024, 32'h0);

        // Short glitch is rejected.
        btn = 4'h1;
        ticks(3);
        btn = 4'h0;
        ticks(8);
        rd_chk("glitch_btn", A_BTN, 32'h0);
        rd_chk("glitch_edge", A_EDGE, 32'h0);

        // Held press accepted after exactly 6 edges.
        btn = 4'h1;
        ticks(5);
        rd_chk("hold_5", A_BTN, 32'h0);
        tick();
        rd_chk("hold_6_btn", A_BTN, 32'h1);
        rd_chk("hold_6_edge", A_EDGE, 32'h1);
        wr(A_EDGE, 32'h1);
        btn = 4'h0;
        ticks(8);

        // Bounce on btn[1].
        for (int i = 0; i < 20; i++) begin
            btn[1] = ((i / 2) % 2 == 0);
            tick();
            rd_chk("bounce_edge", A_EDGE, 32'h0);
        end
        btn[1] = 1'b1;
        ticks(5);
        rd_chk("bounce_5", A_EDGE, 32'h0);
        tick();
        rd_chk("bounce_6", A_EDGE, 32'h2);
        wr(A_EDGE, 32'h2);
        btn = 4'h0;
        ticks(8);

        // Interrupt enabled.
        wr(A_IEN, 32'h1);
        rd_chk("ien_1", A_IEN, 32'h1);
        btn = 4'h1;
        ticks(6);
        rd_chk("irq_flag", A_EDGE, 32'h1);
        chk("irq_lag", {31'b0, irq}, 32'h0);
        tick();
        chk("irq_rise", {31'b0, irq}, 32'h1);
        wr(A_EDGE, 32'h1);
        rd_chk("irq_clr_edge", A_EDGE, 32'h0);
        chk("irq_hold", {31'b0, irq}, 32'h1);
        tick();
        chk("irq_fall", {31'b0, irq}, 32'h0);
        btn = 4'h0;
        ticks(8);

        // Interrupt disabled; upper IEN bits not stored.
        wr(A_IEN, 32'hFFFF_FFF0);
        rd_chk("ien_mask0", A_IEN, 32'h0);
        btn = 4'h1;
        ticks(6);
        rd_chk("noirq_flag", A_EDGE, 32'h1);
        ticks(2);
        chk("noirq", {31'b0, irq}, 32'h0);
        wr(A_EDGE, 32'hF);
        btn = 4'h0;
        ticks(8);
        wr(A_IEN, 32'hFFFF_FFFF);
        rd_chk("ien_maskF", A_IEN, 32'hF);
        wr(A_IEN, 32'h0);

        // Read and write of the same register in one cycle.
        memRead = 1'b1; memWrite = 1'b1; address = A_IEN; dataIn = 32'h5;
        #1 chk("rw_pre", dataOut, 32'h0);
        tick();
        memWrite = 1'b0;
        chk("rw_post", dataOut, 32'h5);
        memRead = 1'b0;
        wr(A_IEN, 32'h0);

        // Set/clear collision on bit 2.
        btn = 4'h4;
        ticks(5);
        wr(A_EDGE, 32'h4);
        rd_chk("collide_set", A_EDGE, 32'h4);
        wr(A_EDGE, 32'h4);
        rd_chk("collide_clr", A_EDGE, 32'h0);
        btn = 4'h0;
        ticks(8);

        // Randomised traffic, model-checked every cycle.
        for (int c = 0; c < 2000; c++) begin
            if (c == 1000) rst = 1'b1;
            if (c == 1002) rst = 1'b0;
            if ($urandom_range(0, 9) == 0) sw = 8'($urandom);
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 5) == 0) btn[b] = ~btn[b];
            memRead  = ($urandom_range(0, 1) == 1);
            memWrite = ($urandom_range(0, 3) == 0);
            address  = addrs[$urandom_range(0, 6)] | 32'($urandom_range(0, 3));
            dataIn   = $urandom;
            tick();
        end
        memRead = 1'b0; memWrite = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mmio_input_port.md
Name: mmio_input_port

Overview:
- Memory-mapped input peripheral on the CPU data bus; the read-direction counterpart of the LED/digit output register.
- Synchronises slide switches and push buttons, debounces the buttons, and latches button press edges as sticky flags with an optional interrupt.
- The CPU reads it with load instructions in the MEM stage and clears flags with stores. It shares the address, memWrite and dataIn bus with the output peripherals.

Parameters:
- NUM_SW, 8, number of slide-switch inputs (1..16).
- NUM_BTN, 4, number of push-button inputs (1..8).
- DEBOUNCE_CYCLES, 20'd1000000, clock cycles a button must hold a new level before it is accepted (>=2).
- CNT_W, 20, width of each debounce counter; must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- memRead  input  1  load strobe from the MEM stage.
- memWrite  input  1  store strobe from the MEM stage.
- address  input  32  byte address from the MEM stage.
- dataIn  input  32  store data.
- sw  input  NUM_SW  raw switch levels, asynchronous.
- btn  input  NUM_BTN  raw button levels, active-high, asynchronous.
- dataOut  output  32  read data; zero when not selected.
- irq  output  1  level interrupt request.

Behaviour:
- Reset is asynchronous and active-high; all state clears immediately on rst.
- Clears to 0: synchronisers, debounce counters, stable levels, edge flags, enable register, irq.

Register map (word addresses; byte offsets ignored):
- 0x40000014 SW: read-only. dataOut[NUM_SW-1:0] = synchronised switches; upper bits 0.
- 0x40000018 BTN: read-only. dataOut[NUM_BTN-1:0] = debounced stable levels.
- 0x4000001C EDGE: read returns sticky rising-edge flags. A write of dataIn bit i = 1 clears flag i (write-1-to-clear). A write of 0 leaves the flag unchanged.
- 0x40000020 IEN: read/write. Only bits [NUM_BTN-1:0] are stored; other bits read as 0.
- Writes to SW or BTN are ignored.
- Reads are side-effect free; no clear-on-read, so pipeline stalls and replays are safe.

Read path:
- dataOut is combinational from address and the current register state, zero-latency, so the pipeline's load path sees it in the same cycle.
- dataOut = 0 when memRead = 0 or the address is not in the map.

Synchronisation:
- Every sw and btn bit passes through a 2-flop synchroniser.
- SW register reflects a raw switch change 2 clock edges later.

Debounce, per button, on the synchronised sample s and stable level q:
- s == q: counter resets to 0.
- s != q and counter < DEBOUNCE_CYCLES-1: counter increments.
- s != q and counter == DEBOUNCE_CYCLES-1: q <= s and counter <= 0.
- A glitch shorter than DEBOUNCE_CYCLES cycles never changes q; any bounce back restarts the count.
- Acceptance latency is 2 synchroniser edges + DEBOUNCE_CYCLES edges after the raw change.

Edge flags:
- Flag i sets on the cycle q_i goes 0->1.
- Falling edges do not set flags.
- If a set and a W1C of the same bit occur in the same cycle, set wins and the flag reads 1.

Interrupt:
- irq is registered: irq <= |(EDGE & IEN).
- It rises one cycle after the flag and IEN are both 1.
- It falls one cycle after the last enabled flag clears or IEN is cleared.

Other rules:
- Simultaneous memRead and memWrite to the same register: the read returns the pre-write value; the write takes effect at the clock edge.
- Reset mid-debounce discards the partial count. After reset release, a button already held high must complete the full debounce interval before q rises and a flag sets.

Test Plan:
- Bench uses DEBOUNCE_CYCLES=4, NUM_SW=8, NUM_BTN=4.
- Reset: assert rst mid-cycle with btn=4'hF and sw=8'hFF -> dataOut=0, irq=0 immediately. After release, a read of 0x40000014 returns 0x000000FF after 2 edges. BTN reads 0x0000000F after 6 edges.
- Switch read: sw=8'hA5, wait 2 edges, memRead to 0x40000014 -> dataOut=0x000000A5. The same read with memRead=0 -> dataOut=0. A read of 0x40000024 -> 0.
- Debounce: btn[0] high for 3 cycles then low -> BTN stays 0, EDGE stays 0. btn[0] held high -> BTN=0x1 and EDGE=0x1 exactly 6 edges after the change.
- Bounce: btn[1] toggling high/low every 2 cycles for 20 cycles then held high -> a single flag set on bit 1, EDGE=0x2, no flag at any toggle.
- Interrupt: write IEN=0x1, press btn[0] -> irq=1 one cycle after EDGE[0]. Write 0x1C with dataIn=0x1 -> EDGE=0, irq=0 next cycle. A press with IEN=0 -> flag sets, irq stays 0.
- Set/clear collision: align a W1C of bit 2 with the debounced rising edge of btn[2] -> EDGE bit 2 reads 1 afterwards. A second W1C clears it to 0.
